// File: rtl/arb_mux_reg_pkg.sv
// Shared definitions for the arb_mux_reg channel multiplexer.
// Holds the arbitration mode encodings used by the top level and the picker.
// The reserved encoding 2'b11 has no name; it behaves like MODE_FORCED.
package arb_mux_reg_pkg;

    localparam logic [1:0] MODE_FORCED = 2'b00;
    localparam logic [1:0] MODE_FIXED  = 2'b01;
    localparam logic [1:0] MODE_RR     = 2'b10;

endpackage

// File: rtl/arb_mux_reg_rr_pick.sv
// Combinational grant picker for arb_mux_reg.
// Fixed priority and round-robin share one rotate / priority-encode /
// un-rotate path. Fixed priority uses a base of N-1, so the search starts
// at channel 0. Forced mode bypasses the encoder and grants i_sel when that
// channel is requesting.
//
// Ports:
//   i_req          N   per-channel request
//   i_ptr          SW  last round-robin grant; the search starts at i_ptr+1
//   i_mode         2   arbitration mode
//   i_sel          SW  forced-mode channel index
//   o_grant_valid  1   a channel is granted
//   o_grant_idx    SW  index of the granted channel
module arb_mux_reg_rr_pick
    import arb_mux_reg_pkg::*;
#(
    parameter  int N  = 4,
    localparam int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [SW-1:0] i_ptr,
    input  logic [1:0]    i_mode,
    input  logic [SW-1:0] i_sel,
    output logic          o_grant_valid,
    output logic [SW-1:0] o_grant_idx
);

    logic [N-1:0] w_rot;
    logic         w_hit;
    int           w_base;
    int           w_off;
    int           w_idx;

    always_comb begin
        w_base = (i_mode == MODE_RR) ? int'(i_ptr) : N - 1;

        // Rotate so that rotated bit 0 is the first channel searched.
        w_rot = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = w_base + 1 + k;
            if (w_idx >= N) w_idx = w_idx - N;
            w_rot[k] = i_req[w_idx[SW-1:0]];
        end

        w_hit = 1'b0;
        w_off = 0;
        for (int k = 0; k < N; k++) begin
            if (!w_hit && w_rot[k]) begin
                w_hit = 1'b1;
                w_off = k;
            end
        end

        // Un-rotate the winning offset back to a channel index.
        w_idx = w_base + 1 + w_off;
        if (w_idx >= N) w_idx = w_idx - N;

        if (i_mode == MODE_FIXED || i_mode == MODE_RR) begin
            o_grant_valid = w_hit;
            o_grant_idx   = w_idx[SW-1:0];
        end else begin
            // Indices at or above N name no channel and never grant.
            o_grant_valid = (int'(i_sel) < N) && i_req[i_sel];
            o_grant_idx   = i_sel;
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// N:1 channel multiplexer with valid/ready handshakes and a registered output.
// A new item is captured whenever the output register is empty or being
// drained. The picker chooses the channel according to the per-cycle mode.
// In round-robin mode the pointer remembers the last grant.
//
// Ports:
//   clk        1    rising-edge clock
//   rst        1    synchronous active-high reset
//   mode       2    00 forced, 01 fixed priority, 10 round-robin, 11 as 00
//   sel        SW   forced-mode channel index
//   in_data    N*W  flattened channel data, channel i at [i*W +: W]
//   in_valid   N    per-channel request
//   in_ready   N    per-channel accept, one-hot or zero
//   out_data   W    registered selected data
//   out_sel    SW   channel index of out_data
//   out_valid  1    out_data holds an untaken item
//   out_ready  1    consumer accept
module arb_mux_reg
    import arb_mux_reg_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int W  = 3,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_sel,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [W-1:0]  r_out_data;
    logic [SW-1:0] r_out_sel;
    logic          r_out_valid;
    logic [SW-1:0] r_ptr;

    logic          w_load;
    logic          w_grant_valid;
    logic [SW-1:0] w_grant_idx;
    logic [W-1:0]  w_ch [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_ch[gi] = in_data[gi*W +: W];
    end

    arb_mux_reg_rr_pick #(.N(N)) u_rr_pick (
        .i_req         (in_valid),
        .i_ptr         (r_ptr),
        .i_mode        (mode),
        .i_sel         (sel),
        .o_grant_valid (w_grant_valid),
        .o_grant_idx   (w_grant_idx)
    );

    assign w_load = ~r_out_valid | out_ready;

    // Accept is suppressed during reset because the capture is discarded.
    assign in_ready = (~rst & w_load & w_grant_valid)
                    ? ({{(N-1){1'b0}}, 1'b1} << w_grant_idx)
                    : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_ptr       <= SW'(N - 1);
        end else if (w_load) begin
            if (w_grant_valid) begin
                r_out_data  <= w_ch[w_grant_idx];
                r_out_sel   <= w_grant_idx;
                r_out_valid <= 1'b1;
                if (mode == MODE_RR) r_ptr <= w_grant_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_arb_mux_reg.sv
module tb_arb_mux_reg;

    localparam int N  = 4;
    localparam int W  = 3;
    localparam int SW = 2;
    localparam logic [N*W-1:0] DATA0 = 12'b010_000_101_110;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     mode;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_sel;
    logic           out_valid;
    logic           out_ready;

    always #5 clk = ~clk;

    arb_mux_reg #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: output register contents and round-robin pointer.
    int m_valid = 0;
    int m_data  = 0;
    int m_sel   = 0;
    int m_ptr   = N - 1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Returns the granted channel or -1, straight from the arbitration rules.
    function automatic int pick(input int md, input int sl, input logic [N-1:0] v, input int p);
        int c;
        if (md == 1) begin
            for (int i = 0; i < N; i++) if (v[i]) return i;
            return -1;
        end else if (md == 2) begin
            for (int k = 1; k <= N; k++) begin
                c = (p + k) % N;
                if (v[c]) return c;
            end
            return -1;
        end else begin
            if (sl < N && v[sl]) return sl;
            return -1;
        end
    endfunction

    // One clock: drive, check accept, clock, update model, check outputs.
    task automatic cyc(input logic r, input logic [1:0] md, input logic [SW-1:0] s,
                       input logic [N-1:0] v, input logic [N*W-1:0] d, input logic ordy);
        int g;
        int ld;
        logic [N-1:0] exp_rdy;
        rst = r; mode = md; sel = s; in_valid = v; in_data = d; out_ready = ordy;
        #2;
        g  = pick(int'(md), int'(s), v, m_ptr);
        ld = (m_valid == 0 || ordy) ? 1 : 0;
        exp_rdy = (!r && ld == 1 && g >= 0) ? N'(1 << g) : '0;
        check_val("in_ready", 32'(in_ready), 32'(exp_rdy));
        @(posedge clk);
        if (r) begin
            m_valid = 0; m_data = 0; m_sel = 0; m_ptr = N - 1;
        end else if (ld == 1) begin
            if (g >= 0) begin
                m_valid = 1;
                m_data  = int'(d[g*W +: W]);
                m_sel   = g;
                if (md == 2'b10) m_ptr = g;
            end else begin
                m_valid = 0;
            end
        end
        #1;
        check_val("out_valid", 32'(out_valid), 32'(m_valid));
        check_val("out_data", 32'(out_data), 32'(m_data));
        check_val("out_sel", 32'(out_sel), 32'(m_sel));
    endtask

    int cnt [N];
    logic [W-1:0] ch_exp [N];

    initial begin
        ch_exp[0] = 3'b110; ch_exp[1] = 3'b101; ch_exp[2] = 3'b000; ch_exp[3] = 3'b010;
        rst = 1'b1; mode = 2'b00; sel = '0; in_valid = '0; in_data = DATA0; out_ready = 1'b0;
        @(posedge clk); #1;

        // Reset state
        cyc(1'b1, 2'b00, 2'd0, 4'b1111, DATA0, 1'b1);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", 32'(out_data), 32'd0);

        // Forced select sweep
        for (int i = 0; i < N; i++) begin
            cyc(1'b0, 2'b00, SW'(i), 4'b1111, DATA0, 1'b1);
            check_val("forced_data", 32'(out_data), 32'(ch_exp[i]));
            check_val("forced_sel", 32'(out_sel), i);
        end

        // Fixed priority, repeated grant of ch1
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'b01, 2'd0, 4'b1010, DATA0, 1'b1);
            check_val("fixed_data", 32'(out_data), 32'(3'b101));
            check_val("fixed_sel", 32'(out_sel), 32'd1);
        end

        // Round-robin from reset, plus fairness over two rounds
        cyc(1'b1, 2'b10, 2'd0, 4'b0000, DATA0, 1'b1);
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int i = 0; i < 2 * N; i++) begin
            cyc(1'b0, 2'b10, 2'd0, 4'b1111, DATA0, 1'b1);
            check_val("rr_sel", 32'(out_sel), i % N);
            check_val("rr_data", 32'(out_data), 32'(ch_exp[i % N]));
            cnt[out_sel]++;
        end
        for (int i = 0; i < N; i++) check_val("rr_fair", cnt[i], 32'd2);

        // Backpressure while holding ch2
        cyc(1'b1, 2'b10, 2'd0, 4'b0000, DATA0, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b10, 2'd0, 4'b1111, DATA0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'b10, 2'd0, 4'b1111, DATA0, 1'b0);
            check_val("bp_ready", 32'(in_ready), 32'd0);
            check_val("bp_sel", 32'(out_sel), 32'd2);
            check_val("bp_data", 32'(out_data), 32'd0);
        end
        cyc(1'b0, 2'b10, 2'd0, 4'b1111, DATA0, 1'b1);
        check_val("bp_next_sel", 32'(out_sel), 32'd3);

        // Empty request and invalid forced select
        cyc(1'b0, 2'b01, 2'd0, 4'b0000, DATA0, 1'b1);
        check_val("empty_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, 2'b10, 2'd0, 4'b1111, DATA0, 1'b1);
        cyc(1'b0, 2'b00, 2'd3, 4'b0111, DATA0, 1'b1);
        check_val("nosel_valid", 32'(out_valid), 32'd0);
        cyc(1'b0, 2'b11, 2'd3, 4'b0111, DATA0, 1'b1);
        check_val("rsvd_valid", 32'(out_valid), 32'd0);

        // Reset mid-stream in round-robin
        cyc(1'b0, 2'b10, 2'd0, 4'b1111, DATA0, 1'b1);
        cyc(1'b0, 2'b10, 2'd0, 4'b1111, DATA0, 1'b0);
        cyc(1'b1, 2'b10, 2'd0, 4'b1111, DATA0, 1'b0);
        check_val("mid_rst_valid", 32'(out_valid), 32'd0);
        check_val("mid_rst_sel", 32'(out_sel), 32'd0);
        cyc(1'b0, 2'b10, 2'd0, 4'b1111, DATA0, 1'b1);
        check_val("mid_rst_next", 32'(out_sel), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 59) == 0),
                2'($urandom_range(0, 3)),
                SW'($urandom_range(0, N - 1)),
                N'($urandom),
                (N*W)'($urandom),
                ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
